ram_bus_master: RTL and testbench
=================================

RAM_BUS_MASTER -- requirements
Module: ram_bus_master

Interface
REQ-001 Parameter READ_WAIT, 1, cycles between address setup and read-data sample (1..7).
REQ-002 Parameter WRITE_HOLD, 1, cycles write data is driven with mem_wre low (1..7).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  master can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load data, valid with resp_valid and req_we=0.
REQ-012 resp_err  output  1  request rejected, valid with resp_valid.
REQ-013 mem_addr  output  7  word address to RAM.
REQ-014 mem_data  inout  32  shared tristate data bus.
REQ-015 mem_wre  output  1  1 = RAM drives/read, 0 = RAM writes bus value.

Function
REQ-016 States SHALL be IDLE, W_SETUP, W_DRIVE, R_WAIT, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready at a rising edge.
REQ-018 On handshake, request SHALL be rejected if req_addr[1:0] != 0 or req_addr[31:9] != 0: next state RESP with resp_err=1, no bus activity, mem_wre stays 1.
REQ-019 Accepted request SHALL latch mem_addr = req_addr[8:2], req_wdata, req_we; mem_addr SHALL stay constant until the next accepted request.
REQ-020 Store: IDLE -> W_SETUP (mem_wre=0, bus not driven, 1 cycle) -> W_DRIVE (mem_wre=0, bus driven with latched data, WRITE_HOLD cycles) -> RESP.
REQ-021 On the W_DRIVE -> RESP edge, mem_wre SHALL return to 1 and the bus drive SHALL be released on the same edge; the bus SHALL never be driven while mem_wre=1.
REQ-022 Load: IDLE -> R_WAIT (mem_wre=1, READ_WAIT cycles) -> RESP; mem_data SHALL be sampled into resp_rdata on the R_WAIT -> RESP edge.
REQ-023 RESP SHALL last exactly 1 cycle with resp_valid=1, then IDLE; resp_err=0 for accepted requests.
REQ-024 Latency handshake-to-resp_valid: store 1+WRITE_HOLD+1, load READ_WAIT+1, error 1 cycles.
REQ-025 resp_rdata SHALL hold its value until the next load completes; stores and errors SHALL NOT change it.
REQ-026 Wait counter SHALL be 3 bits, load N-1 on state entry, decrement, exit at 0; no wrap.
REQ-027 mem_wre SHALL be 1 in IDLE, R_WAIT and RESP so an idle bus never writes RAM.
REQ-028 req_valid during non-IDLE states SHALL be ignored (no queueing); requester holds it.

Reset
REQ-029 On reset=0 at a rising edge: state IDLE, mem_wre=1, bus released, mem_addr=0, resp_valid=0, resp_err=0, resp_rdata=0, counter=0.
REQ-030 Reset mid-transaction SHALL abort it with no response; an interrupted store leaves that RAM word undefined.

Structure
REQ-031 Package ram_bus_pkg SHALL hold the state enum, MEM_AW=7, MEM_DW=32 and the address-check helper.
REQ-032 Single FSM module; no sub-module; tristate driver inline, controlled by one registered drive-enable flop.
REQ-033 All outputs including mem_wre and drive enable SHALL come from flops.

Verification
REQ-034 Store 0x0000_0010 <- 0xDEAD_BEEF, WRITE_HOLD=1 -> mem_addr=4, mem_wre low 2 cycles, bus driven only in the second, resp_valid at cycle 3, RAM word 4 = 0xDEADBEEF.
REQ-035 Load 0x0000_0010 after REQ-034, READ_WAIT=1 -> resp_valid at cycle 2, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-036 Load 0x0000_0012 and store 0x0000_0200 -> resp_valid next cycle with resp_err=1, mem_wre never low, resp_rdata unchanged.
REQ-037 Back-to-back store/load to 0x1FC, READ_WAIT=3, WRITE_HOLD=2 -> latencies 4 and 4, mem_addr=127, readback equal, bus never multiply driven (no X on mem_data).
REQ-038 Assert reset=0 during W_DRIVE -> next cycle IDLE, mem_wre=1, bus Z, no resp_valid; subsequent load completes normally.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// Shared types and constants for the single-port RAM bus master.
package ram_bus_pkg;

  localparam int MEM_AW = 7;
  localparam int MEM_DW = 32;
  localparam int CNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_SETUP = 3'd1,
    W_DRIVE = 3'd2,
    R_WAIT  = 3'd3,
    RESP    = 3'd4
  } state_t;

  // A request is serviceable only if it is word aligned and inside the
  // 128-word window the RAM decodes.
  function automatic logic addr_ok(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr[31:9] == 23'd0);
  endfunction

endpackage

// File: rtl/ram_bus_master.sv
// Single-request bus master for an asynchronous single-port RAM with a
// shared tristate data bus. One request is in flight at a time; the
// direction of the current transfer is carried by the FSM state itself.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int READ_WAIT  = 1,
  parameter int WRITE_HOLD = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic                resp_err,
  output logic [MEM_AW-1:0]   mem_addr,
  inout  wire  [MEM_DW-1:0]   mem_data,
  output logic                mem_wre
);

  // Counter reload values: the wait state lasts N cycles, counting N-1..0.
  localparam logic [CNT_W-1:0] RW_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WH_LOAD = CNT_W'(WRITE_HOLD - 1);

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [MEM_AW-1:0]   addr_r, addr_s;
  logic [MEM_DW-1:0]   wdata_r, wdata_s;
  logic [MEM_DW-1:0]   rdata_r, rdata_s;
  logic                resp_valid_r, resp_valid_s;
  logic                resp_err_r, resp_err_s;
  logic                wre_r, wre_s;
  logic                drive_r, drive_s;
  logic                ready_r, ready_s;
  logic                handshake_s;

  assign handshake_s = req_valid & ready_r;

  // Bus driver: only the registered drive enable may put data on the bus,
  // and it is only ever set while mem_wre is also registered low.
  assign mem_data = drive_r ? wdata_r : {MEM_DW{1'bz}};

  assign req_ready  = ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = rdata_r;
  assign mem_addr   = addr_r;
  assign mem_wre    = wre_r;

  // Next-state and next-output logic; every output is computed one cycle
  // ahead so that the flops below present it glitch-free.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    rdata_s      = rdata_r;
    resp_valid_s = 1'b0;
    resp_err_s   = 1'b0;
    wre_s        = 1'b1;
    drive_s      = 1'b0;
    ready_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (handshake_s) begin
          if (!addr_ok(req_addr)) begin
            // Rejected: straight to the response, bus untouched.
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_err_s   = 1'b1;
          end else begin
            addr_s  = req_addr[8:2];
            wdata_s = req_wdata;
            if (req_we) begin
              state_s = W_SETUP;
              wre_s   = 1'b0;
              cnt_s   = {CNT_W{1'b0}};
            end else begin
              state_s = R_WAIT;
              cnt_s   = RW_LOAD;
            end
          end
        end else begin
          ready_s = 1'b1;
        end
      end

      W_SETUP: begin
        // Address and write strobe have settled; start driving data.
        state_s = W_DRIVE;
        wre_s   = 1'b0;
        drive_s = 1'b1;
        cnt_s   = WH_LOAD;
      end

      W_DRIVE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          // Strobe rises and drive releases on the same edge.
          state_s      = RESP;
          resp_valid_s = 1'b1;
        end else begin
          cnt_s   = cnt_r - 3'd1;
          wre_s   = 1'b0;
          drive_s = 1'b1;
        end
      end

      R_WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s      = RESP;
          resp_valid_s = 1'b1;
          rdata_s      = mem_data;
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end

      RESP: begin
        state_s = IDLE;
        ready_s = 1'b1;
      end

      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
        ready_s = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset; reset
  // abandons any transfer in progress without producing a response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      addr_r       <= {MEM_AW{1'b0}};
      wdata_r      <= {MEM_DW{1'b0}};
      rdata_r      <= {MEM_DW{1'b0}};
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      wre_r        <= 1'b1;
      drive_r      <= 1'b0;
      ready_r      <= 1'b1;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      rdata_r      <= rdata_s;
      resp_valid_r <= resp_valid_s;
      resp_err_r   <= resp_err_s;
      wre_r        <= wre_s;
      drive_r      <= drive_s;
      ready_r      <= ready_s;
    end
  end

endmodule

// File: tb/tb_ram_bus_master.sv
// Self-checking bench for ram_bus_master: a behavioural RAM on the shared
// bus, a word-level shadow memory as reference, directed cases followed by
// randomized loads/stores/rejects.
module tb_ram_bus_master;

  localparam int RW = 3;
  localparam int WH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  wire         req_ready;
  wire         resp_valid;
  wire         resp_err;
  wire  [31:0] resp_rdata;
  wire  [6:0]  mem_addr;
  wire         mem_wre;
  wire  [31:0] mem_data;

  logic [31:0] ram [0:127];
  logic [31:0] model_mem [0:127];
  bit          model_def [0:127];
  logic [31:0] model_rdata;
  logic [6:0]  model_addr;
  int          vectors = 0;
  int          miscompares = 0;

  ram_bus_master #(.READ_WAIT(RW), .WRITE_HOLD(WH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wre(mem_wre)
  );

  always #5 clk = ~clk;

  // The RAM drives the bus whenever its write strobe is high.
  assign mem_data = mem_wre ? ram[mem_addr] : 32'bz;

  // The RAM stores whatever is validly on the bus while the strobe is low.
  always @(negedge clk) begin
    if (mem_wre === 1'b0 && !$isunknown(mem_data)) ram[mem_addr] <= mem_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the master to be ready, then present one request.
  task automatic handshake(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic run_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bit         ok, seen, xbus;
    int         lat, low_cnt, exp_lat;
    logic [6:0] w;
    ok      = (addr[1:0] == 2'b00) && (addr < 32'h200);
    w       = addr[8:2];
    exp_lat = !ok ? 1 : (we ? 2 + WH : RW + 1);
    handshake(we, addr, wdata);
    lat = 0; low_cnt = 0; seen = 1'b0; xbus = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check_eq("ready_busy", 32'(req_ready), 32'd0);
      if (mem_wre === 1'b0) begin
        low_cnt++;
        if (low_cnt == 1 && wdata != 32'd0)
          check_eq("setup_undriven", 32'(mem_data === wdata), 32'd0);
      end
      if (mem_wre === 1'b1 && $isunknown(mem_data)) xbus = 1'b1;
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    check_eq("latency", 32'(lat), 32'(exp_lat));
    check_eq("resp_err", 32'(resp_err), 32'(!ok));
    check_eq("wre_low_cycles", 32'(low_cnt), (ok && we) ? 32'(1 + WH) : 32'd0);
    if (ok) model_addr = w;
    check_eq("mem_addr", 32'(mem_addr), 32'(model_addr));
    if (ok && !we) begin
      if (model_def[w]) check_eq("load_data", resp_rdata, model_mem[w]);
      model_rdata = resp_rdata;
    end else begin
      check_eq("rdata_hold", resp_rdata, model_rdata);
    end
    if (ok && we) begin
      model_mem[w] = wdata;
      model_def[w] = 1'b1;
    end
    check_eq("bus_conflict", 32'(xbus), 32'd0);
    @(negedge clk);
    check_eq("resp_pulse", 32'(resp_valid), 32'd0);
    check_eq("ready_after", 32'(req_ready), 32'd1);
    if (ok && we) check_eq("ram_word", ram[w], wdata);
  endtask

  // Start a store and pull reset in the first data-drive cycle.
  task automatic reset_during_drive(input logic [31:0] addr, input logic [31:0] wdata);
    int low_cnt, n;
    handshake(1'b1, addr, wdata);
    low_cnt = 0; n = 0;
    while (low_cnt < 2 && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_wre === 1'b0) low_cnt++;
    end
    check_eq("reached_drive", 32'(low_cnt), 32'd2);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_eq("abort_ready", 32'(req_ready), 32'd1);
    check_eq("abort_wre", 32'(mem_wre), 32'd1);
    check_eq("abort_resp", 32'(resp_valid), 32'd0);
    check_eq("abort_addr", 32'(mem_addr), 32'd0);
    check_eq("abort_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    check_eq("abort_noresp", 32'(resp_valid), 32'd0);
    model_def[addr[8:2]] = 1'b0;
    model_addr  = 7'd0;
    model_rdata = 32'd0;
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    for (int i = 0; i < 128; i++) begin
      ram[i]       = 32'h3C00_0000 + 32'(i) * 32'h0001_0101;
      model_mem[i] = 32'h3C00_0000 + 32'(i) * 32'h0001_0101;
      model_def[i] = 1'b1;
    end
    model_rdata = 32'd0;
    model_addr  = 7'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_wre", 32'(mem_wre), 32'd1);
    check_eq("rst_resp", 32'(resp_valid), 32'd0);
    check_eq("rst_err", 32'(resp_err), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    run_req(1'b0, 32'h0000_0010, 32'd0);
    run_req(1'b0, 32'h0000_0012, 32'd0);
    run_req(1'b1, 32'h0000_0200, 32'h1234_5678);
    run_req(1'b1, 32'h0000_01FC, 32'hCAFE_F00D);
    run_req(1'b0, 32'h0000_01FC, 32'd0);
    reset_during_drive(32'h0000_0020, 32'h55AA_55AA);
    run_req(1'b0, 32'h0000_0024, 32'd0);

    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)       a = {23'd0, 7'($urandom_range(0, 15)), 2'b00};
      else if (r == 6) a = 32'h0000_01FC;
      else if (r == 7) a = {23'd0, 7'($urandom_range(0, 127)), 2'($urandom_range(1, 3))};
      else             a = ($urandom | 32'h0000_0200) & 32'hFFFF_FFFC;
      run_req(1'($urandom), a, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
